multicycle_controller: RTL
==========================

# multicycle_controller

Main control FSM of the multi-cycle MIPS datapath. It drives the ALU's `ALUConf`/`Sign` inputs and consumes its `Zero`/`overflow` outputs, so it is the initiator side of the ALU interface. It also sequences PC, instruction register, memory and register-file enables through fetch, decode, execute, memory and write-back. Outputs are decoded from a registered state plus latched flags.

## Interface
- `EXC_EN`, default 1: when 1, signed-add/sub overflow suppresses write-back and pulses `exc_flag`.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high.
- `OpCode` input 6: IR[31:26]; valid from ID onward.
- `Funct` input 6: IR[5:0].
- `Zero` input 1: ALU result-is-zero.
- `overflow` input 1: ALU signed overflow, valid for add (00000) and sub (00110).
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `RegWrite` output 1 each: datapath enables.
- `RegDst` output 2: 00 rt, 01 rd, 10 $31.
- `MemtoReg` output 2: 00 ALUOut, 01 MDR, 10 PC.
- `ALUSrcA` output 2: 00 PC, 01 A, 10 shamt.
- `ALUSrcB` output 2: 00 B, 01 const 4, 10 ext imm, 11 ext imm<<2.
- `PCSource` output 2: 00 ALU result, 01 ALUOut, 10 jump target, 11 A.
- `ExtOp` output 1: 1 sign-extend, 0 zero-extend.
- `LuiOp` output 1: imm<<16.
- `ALUConf` output 5: ALU operation.
- `Sign` output 1: signed compare.
- `exc_flag` output 1: one-cycle overflow-exception pulse.
- `retired` output 32: count of completed instructions.

## Operation
- States (3-bit): IF=0, ID=1, EX=2, MEM=3, WB=4. Undefined codes go to IF.
- IF: MemRead, IRWrite, PCWrite; IorD=0; ALUSrcA=00; ALUSrcB=01; ALUConf=add; PCSource=00. Next state ID.
- ID: ALUSrcA=00, ALUSrcB=11, ExtOp=1, ALUConf=add (branch target into ALUOut).
  - j: PCWrite, PCSource=10, go to IF.
  - jal: same as j, plus RegWrite, RegDst=10, MemtoReg=10.
  - All other supported opcodes go to EX.
  - Unsupported opcode/funct: treat as nop, go to IF, count retired.
- EX:
  - R-type: ALUSrcA=01, or 10 for sll/srl/sra; ALUSrcB=00.
  - I-type: ALUSrcA=01, ALUSrcB=10.
  - ALUConf mapping:
    - add/addu/addi/addiu/lw/sw/lui: 00000.
    - sub/subu: 00110.
    - and/andi: 00010.
    - or/ori: 00001.
    - xor: 01101.
    - nor: 01100.
    - slt/slti/sltu/sltiu: 00111.
    - srl: 10000.
    - sra: 11000.
    - sll: 11001.
  - Sign=1 for slt/slti, 0 for sltu/sltiu, 1 otherwise.
  - ExtOp=0 for andi/ori, else 1. LuiOp=1 for lui.
  - beq: ALUConf=00110, PCWriteCond=1, PCSource=01, go to IF.
  - jr: PCWrite, PCSource=11, go to IF.
  - jalr: same as jr, plus RegWrite, RegDst=01, MemtoReg=10.
  - lw/sw go to MEM; others go to WB.
  - Overflow is latched in `ovf_q` at the EX edge only for add, sub and addi.
- MEM: IorD=1. lw asserts MemRead and goes to WB. sw asserts MemWrite and goes to IF.
- WB: RegWrite with RegDst=01/MemtoReg=00 (R-type), 00/00 (I-type ALU) or 00/01 (lw). Go to IF.
  - If `EXC_EN` and `ovf_q`: RegWrite=0 and `exc_flag`=1. The instruction still counts as retired.
- `retired` increments on every transition into IF from a non-IF state and wraps at 2^32.
- Any enable not listed for a state is 0. `ALUConf` is 00000 when not specified.

## Timing
- Reset, asynchronous and immediate: state=IF, `ovf_q`=0, `retired`=0. All enables and `exc_flag` read 0 while reset is high.
- After reset releases, the first rising edge executes IF.
- Cycles per instruction: j/jal 2; beq/jr/jalr 3; R-type, I-type ALU and sw 4; lw 5.
- Outputs are combinational in state, `OpCode`, `Funct` and `ovf_q`. `Zero` is used only combinationally in the same EX cycle.
- Reset asserted mid-instruction: the instruction is abandoned and no partial write occurs after the reset edge.

## Structure
- Shared package `mips_defs`:
  - ALUConf codes (ALU_ADD..ALU_ANDN=11010).
  - Opcode/funct constants.
  - State encodings.
  - Mux-select encodings.
- One natural sub-module, `alu_op_decode`: combinational opcode/funct to ALUConf/Sign/ExtOp/LuiOp.

## Test plan
- Reset mid-EX of an R-type add → state IF, `retired`=0, no RegWrite pulse; next fetch asserts IRWrite/PCWrite in the first cycle.
- add $3,$1,$2 with overflow=0 → 4 cycles, EX ALUConf=00000, WB RegWrite=1 RegDst=01, `retired`+1.
- add with overflow=1 in EX → WB RegWrite=0, `exc_flag`=1 for 1 cycle. The same stimulus with addu → RegWrite=1, `exc_flag`=0.
- beq with Zero=1 → EX PCWriteCond=1, PCSource=01, ALUConf=00110, total 3 cycles. With Zero=0 → 3 cycles, back to IF.
- lw then sw → 5 cycles then 4; MEM IorD=1 with MemRead, then MemWrite; lw WB MemtoReg=01.
- jal → 2 cycles; ID RegWrite=1, RegDst=10, MemtoReg=10, PCSource=10. sltiu → ALUConf=00111, Sign=0. `retired` preloaded near 0xFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/mips_defs.sv
// mips_defs: shared encodings for the multi-cycle MIPS controller.
// Rev 1.0
`default_nettype none
package mips_defs;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_OR   = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_SUB  = 5'b00110;
  localparam logic [4:0] ALU_SLT  = 5'b00111;
  localparam logic [4:0] ALU_NOR  = 5'b01100;
  localparam logic [4:0] ALU_XOR  = 5'b01101;
  localparam logic [4:0] ALU_SRL  = 5'b10000;
  localparam logic [4:0] ALU_SRA  = 5'b11000;
  localparam logic [4:0] ALU_SLL  = 5'b11001;
  localparam logic [4:0] ALU_ANDN = 5'b11010;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_A     = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_S2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_A      = 2'b11;

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
// alu_op_decode: opcode/funct to ALUConf, Sign, ExtOp, LuiOp plus a supported flag.
// Rev 1.0
`default_nettype none
module alu_op_decode
  import mips_defs::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [4:0] alu_conf_o,
  output logic       sign_o,
  output logic       ext_op_o,
  output logic       lui_op_o,
  output logic       valid_o
);

  always_comb begin
    alu_conf_o = ALU_ADD;
    sign_o     = 1'b1;
    ext_op_o   = 1'b1;
    lui_op_o   = 1'b0;
    valid_o    = 1'b1;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD, FN_ADDU, FN_JR, FN_JALR: alu_conf_o = ALU_ADD;
          FN_SUB, FN_SUBU:                 alu_conf_o = ALU_SUB;
          FN_AND:                          alu_conf_o = ALU_AND;
          FN_OR:                           alu_conf_o = ALU_OR;
          FN_XOR:                          alu_conf_o = ALU_XOR;
          FN_NOR:                          alu_conf_o = ALU_NOR;
          FN_SLT:                          alu_conf_o = ALU_SLT;
          FN_SLTU: begin
            alu_conf_o = ALU_SLT;
            sign_o     = 1'b0;
          end
          FN_SRL:                          alu_conf_o = ALU_SRL;
          FN_SRA:                          alu_conf_o = ALU_SRA;
          FN_SLL:                          alu_conf_o = ALU_SLL;
          default:                         valid_o    = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_ADDI, OP_ADDIU, OP_LW, OP_SW: alu_conf_o = ALU_ADD;
      OP_LUI:   lui_op_o   = 1'b1;
      OP_BEQ:   alu_conf_o = ALU_SUB;
      OP_SLTI:  alu_conf_o = ALU_SLT;
      OP_SLTIU: begin
        alu_conf_o = ALU_SLT;
        sign_o     = 1'b0;
      end
      OP_ANDI: begin
        alu_conf_o = ALU_AND;
        ext_op_o   = 1'b0;
      end
      OP_ORI: begin
        alu_conf_o = ALU_OR;
        ext_op_o   = 1'b0;
      end
      default: valid_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
// multicycle_controller: IF/ID/EX/MEM/WB control FSM for the multi-cycle MIPS datapath.
// Rev 1.0
`default_nettype none
module multicycle_controller
  import mips_defs::*;
#(
  parameter bit EXC_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  OpCode,
  input  logic [5:0]  Funct,
  input  logic        Zero,
  input  logic        overflow,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic        ExtOp,
  output logic        LuiOp,
  output logic [4:0]  ALUConf,
  output logic        Sign,
  output logic        exc_flag,
  output logic [31:0] retired
);

  state_t      state_q, state_d;
  logic        ovf_q;
  logic [31:0] retired_q;

  logic [4:0] dec_conf;
  logic       dec_sign, dec_ext, dec_lui, dec_valid;

  alu_op_decode u_alu_op_decode (
    .opcode_i   (OpCode),
    .funct_i    (Funct),
    .alu_conf_o (dec_conf),
    .sign_o     (dec_sign),
    .ext_op_o   (dec_ext),
    .lui_op_o   (dec_lui),
    .valid_o    (dec_valid)
  );

  logic is_r, is_shift, is_jr, is_jalr, is_j, is_jal, is_beq, is_lw, is_sw;
  logic is_ovf_op, exc_w;

  assign is_r      = (OpCode == OP_RTYPE);
  assign is_shift  = is_r && (Funct == FN_SLL || Funct == FN_SRL || Funct == FN_SRA);
  assign is_jr     = is_r && (Funct == FN_JR);
  assign is_jalr   = is_r && (Funct == FN_JALR);
  assign is_j      = (OpCode == OP_J);
  assign is_jal    = (OpCode == OP_JAL);
  assign is_beq    = (OpCode == OP_BEQ);
  assign is_lw     = (OpCode == OP_LW);
  assign is_sw     = (OpCode == OP_SW);
  assign is_ovf_op = (is_r && (Funct == FN_ADD || Funct == FN_SUB)) || (OpCode == OP_ADDI);
  assign exc_w     = EXC_EN && ovf_q;

  // Zero is combined with PCWriteCond inside the datapath, not here.
  logic unused_zero;
  assign unused_zero = Zero;

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:  state_d = S_ID;
      S_ID:  state_d = (!dec_valid || is_j || is_jal) ? S_IF : S_EX;
      S_EX: begin
        if (is_beq || is_jr || is_jalr) state_d = S_IF;
        else if (is_lw || is_sw)        state_d = S_MEM;
        else                            state_d = S_WB;
      end
      S_MEM: state_d = is_lw ? S_WB : S_IF;
      S_WB:  state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IF;
      ovf_q     <= 1'b0;
      retired_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_EX) ovf_q <= is_ovf_op && overflow;
      if (state_q != S_IF && state_d == S_IF) retired_q <= retired_q + 32'd1;
    end
  end

  assign retired = retired_q;

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = REGDST_RT;
    MemtoReg    = M2R_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_B;
    PCSource    = PCSRC_ALU;
    ExtOp       = 1'b0;
    LuiOp       = 1'b0;
    ALUConf     = ALU_ADD;
    Sign        = 1'b1;
    exc_flag    = 1'b0;
    case (state_q)
      S_IF: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = SRCB_4;
      end
      S_ID: begin
        ALUSrcB = SRCB_IMM_S2;
        ExtOp   = 1'b1;
        if (is_j || is_jal) begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_JUMP;
        end
        if (is_jal) begin
          RegWrite = 1'b1;
          RegDst   = REGDST_RA;
          MemtoReg = M2R_PC;
        end
      end
      S_EX: begin
        ALUConf = dec_conf;
        Sign    = dec_sign;
        ExtOp   = dec_ext;
        LuiOp   = dec_lui;
        ALUSrcA = (is_r && is_shift) ? SRCA_SHAMT : SRCA_A;
        ALUSrcB = (is_r || is_beq) ? SRCB_B : SRCB_IMM;
        if (is_beq) begin
          PCWriteCond = 1'b1;
          PCSource    = PCSRC_ALUOUT;
        end
        if (is_jr || is_jalr) begin
          PCWrite  = 1'b1;
          PCSource = PCSRC_A;
        end
        if (is_jalr) begin
          RegWrite = 1'b1;
          RegDst   = REGDST_RD;
          MemtoReg = M2R_PC;
        end
      end
      S_MEM: begin
        IorD     = 1'b1;
        MemRead  = is_lw;
        MemWrite = is_sw;
      end
      S_WB: begin
        RegWrite = !exc_w;
        exc_flag = exc_w;
        RegDst   = is_r ? REGDST_RD : REGDST_RT;
        MemtoReg = is_lw ? M2R_MDR : M2R_ALUOUT;
      end
      default: ;
    endcase
    // The state register already reads IF during reset; hold all enables low too.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      exc_flag    = 1'b0;
    end
  end

endmodule
`default_nettype wire
